// File: rtl/uart_core_param_if.sv
// Byte-stream side of the UART core: TX and RX valid/ready channels plus receive status flags.
interface uart_core_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_core_param.sv
// Parametrised full-duplex UART: shared 16x oversample tick, TX and RX FSMs, RX output register.
module uart_core_param #(
  parameter int DIVISOR    = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               loopback,
  uart_core_param_if.slave   bus,
  output logic               txd,
  input  logic               rxd
);

  localparam int         DIV_W     = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic [4:0] STOP_LAST = 5'(STOP_BITS * 16 - 1);

  function automatic logic calc_par(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  // Oversample tick: registered, so it is high for the cycle after the counter wraps
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick    <= (div_cnt == DIV_LAST);
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
    end
  end

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

  tx_state_t            tx_state;
  logic [4:0]           tx_ph;
  logic [3:0]           tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic                 tx_bit_val;
  logic                 tx_accept;

  assign tx_accept = bus.tx_valid && bus.tx_ready;

  always_comb begin
    tx_bit_val = 1'b1;
    case (tx_state)
      TX_START: tx_bit_val = 1'b0;
      TX_DATA:  tx_bit_val = tx_sh[0];
      TX_PAR:   tx_bit_val = tx_par;
      default:  tx_bit_val = 1'b1;
    endcase
  end

  // TX: a state's line level is driven on its first tick, so each bit lasts exactly 16 ticks
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state     <= TX_IDLE;
      tx_ph        <= '0;
      tx_bit       <= '0;
      txd          <= 1'b1;
      bus.tx_ready <= 1'b1;
    end else if (tx_state == TX_IDLE) begin
      if (tx_accept) begin
        tx_state     <= TX_START;
        tx_ph        <= '0;
        tx_bit       <= '0;
        bus.tx_ready <= 1'b0;
      end
    end else if (tick) begin
      tx_ph <= tx_ph + 5'd1;
      if (tx_ph == 5'd0) txd <= tx_bit_val;
      case (tx_state)
        TX_START: if (tx_ph == 5'd15) begin
          tx_state <= TX_DATA;
          tx_ph    <= '0;
        end
        TX_DATA: if (tx_ph == 5'd15) begin
          tx_ph  <= '0;
          tx_bit <= tx_bit + 4'd1;
          if (tx_bit == LAST_BIT) tx_state <= (PARITY_EN != 0) ? TX_PAR : TX_STOP;
        end
        TX_PAR: if (tx_ph == 5'd15) begin
          tx_state <= TX_STOP;
          tx_ph    <= '0;
        end
        TX_STOP: if (tx_ph == STOP_LAST) begin
          tx_state     <= TX_IDLE;
          tx_ph        <= '0;
          bus.tx_ready <= 1'b1;
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_accept) begin
      tx_sh  <= bus.tx_data;
      tx_par <= calc_par(bus.tx_data);
    end else if (tick && tx_state == TX_DATA && tx_ph == 5'd15) begin
      tx_sh <= tx_sh >> 1;
    end
  end

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;

  rx_state_t            rx_state;
  logic [3:0]           rx_ph;
  logic [3:0]           rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_perr;
  logic                 armed;
  logic                 lb_sel;
  logic                 rx_src;
  logic                 sync_p0;
  logic                 sync_p1;
  logic                 rx_done;

  // Loopback select is live while idle and frozen for the rest of a frame
  assign rx_src = ((rx_state == RX_IDLE) ? loopback : lb_sel) ? txd : rxd;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rx_src;
      sync_p1 <= sync_p0;
    end
  end

  assign rx_done = tick && (rx_state == RX_STOP) && (rx_ph == 4'd15);

  // RX: start re-checked 8 ticks in, then every bit sampled 16 ticks apart (mid-bit)
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_ph    <= '0;
      rx_bit   <= '0;
      rx_perr  <= 1'b0;
      armed    <= 1'b1;
      lb_sel   <= 1'b0;
    end else if (tick) begin
      rx_ph <= rx_ph + 4'd1;
      case (rx_state)
        RX_IDLE: begin
          rx_ph <= '0;
          if (!sync_p1 && armed) begin
            rx_state <= RX_START;
            rx_perr  <= 1'b0;
            lb_sel   <= loopback;
          end else if (sync_p1) begin
            armed <= 1'b1;
          end
        end
        RX_START: if (rx_ph == 4'd7) begin
          rx_ph    <= '0;
          rx_bit   <= '0;
          rx_state <= sync_p1 ? RX_IDLE : RX_DATA;
        end
        RX_DATA: if (rx_ph == 4'd15) begin
          rx_bit <= rx_bit + 4'd1;
          if (rx_bit == LAST_BIT) rx_state <= (PARITY_EN != 0) ? RX_PAR : RX_STOP;
        end
        RX_PAR: if (rx_ph == 4'd15) begin
          rx_perr  <= (sync_p1 != calc_par(rx_sh));
          rx_state <= RX_STOP;
        end
        RX_STOP: if (rx_ph == 4'd15) begin
          armed    <= sync_p1;
          rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tick && rx_state == RX_DATA && rx_ph == 4'd15) rx_sh <= {sync_p1, rx_sh[DATA_BITS-1:1]};
  end

  // Output register: a consume in the completion cycle frees the slot for the new word
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.rx_valid      <= 1'b0;
      bus.rx_data       <= '0;
      bus.rx_parity_err <= 1'b0;
      bus.rx_frame_err  <= 1'b0;
      bus.rx_overrun    <= 1'b0;
    end else begin
      if (bus.rx_valid && bus.rx_ready) bus.rx_valid <= 1'b0;
      if (rx_done) begin
        if (!bus.rx_valid || bus.rx_ready) begin
          bus.rx_valid      <= 1'b1;
          bus.rx_data       <= rx_sh;
          bus.rx_parity_err <= rx_perr;
          bus.rx_frame_err  <= !sync_p1;
        end else begin
          bus.rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Bench for uart_core_param: 8N1 and 8E2 instances, directed frames plus random traffic vs a word-level model.
module tb_uart_core_param;
  localparam int BIT = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loopback_a = 1'b0, loopback_b = 1'b0;
  logic rxd_a = 1'b1, rxd_b = 1'b1;
  logic txd_a, txd_b;

  uart_core_param_if #(.DATA_BITS(8)) ifa ();
  uart_core_param_if #(.DATA_BITS(8)) ifb ();

  uart_core_param #(.DIVISOR(2), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut_a (
    .clk(clk), .rst(rst), .loopback(loopback_a), .bus(ifa.slave), .txd(txd_a), .rxd(rxd_a));

  uart_core_param #(.DIVISOR(2), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_dut_b (
    .clk(clk), .rst(rst), .loopback(loopback_b), .bus(ifb.slave), .txd(txd_b), .rxd(rxd_b));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic txd_a_q = 1'b1;
  int falls_a[$];
  logic [9:0] qa[$];
  logic [9:0] qb[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    txd_a_q <= txd_a;
    if (txd_a_q && !txd_a) falls_a.push_back(cyc);
    if (ifa.rx_valid && ifa.rx_ready) qa.push_back({ifa.rx_parity_err, ifa.rx_frame_err, ifa.rx_data});
    if (ifb.rx_valid && ifb.rx_ready) qb.push_back({ifb.rx_parity_err, ifb.rx_frame_err, ifb.rx_data});
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_rxd(input bit b, input logic v);
    if (b) rxd_b = v; else rxd_a = v;
  endtask

  // Frame on the serial line: start, 8 data LSB first, optional parity, one stop, then idle
  task automatic drive_frame(input bit b, input logic [7:0] d, input bit has_par, input logic par, input logic stop);
    set_rxd(b, 1'b0); repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin set_rxd(b, d[i]); repeat (BIT) @(negedge clk); end
    if (has_par) begin set_rxd(b, par); repeat (BIT) @(negedge clk); end
    set_rxd(b, stop); repeat (BIT) @(negedge clk);
    set_rxd(b, 1'b1); repeat (2 * BIT) @(negedge clk);
  endtask

  task automatic tx_send(input bit b, input logic [7:0] d);
    int n = 0;
    if (b) begin ifb.tx_data = d; ifb.tx_valid = 1'b1; end
    else begin ifa.tx_data = d; ifa.tx_valid = 1'b1; end
    while (!(b ? ifb.tx_ready : ifa.tx_ready) && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) chk("tx_accept_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic expect_word(input bit b, input string tag, input logic [9:0] exp);
    int n = 0;
    while ((b ? qb.size() : qa.size()) == 0 && n < 2000) begin @(negedge clk); n++; end
    if ((b ? qb.size() : qa.size()) == 0) chk({tag, "_timeout"}, 0, 1);
    else if (b) chk(tag, qb.pop_front(), exp);
    else chk(tag, qa.pop_front(), exp);
  endtask

  initial begin
    logic txd_log[400];
    logic [7:0] w;
    logic [7:0] sent[$];
    int ready_low, f, run, hi, found;

    ifa.tx_data = 8'hA5; ifa.tx_valid = 1'b1; ifa.rx_ready = 1'b1;
    ifb.tx_data = 8'h00; ifb.tx_valid = 1'b0; ifb.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_txd", txd_a, 1);
    chk("rst_tx_ready", ifa.tx_ready, 1);
    chk("rst_rx_valid", ifa.rx_valid, 0);
    chk("rst_rx_data", ifa.rx_data, 0);
    chk("rst_flags", {ifa.rx_parity_err, ifa.rx_frame_err, ifa.rx_overrun}, 0);
    rst = 1'b0;

    // 8N1 transmit of A5 straight out of reset
    ready_low = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      txd_log[i] = txd_a;
      if (!ifa.tx_ready) begin ready_low++; ifa.tx_valid = 1'b0; end
    end
    f = -1;
    for (int i = 0; i < 400; i++) if (f < 0 && txd_log[i] == 1'b0) f = i;
    if (f < 0 || f > 40) chk("tx_start_seen", 0, 1);
    else begin
      run = 0;
      for (int i = f; i < 400; i++) begin
        if (txd_log[i] != 1'b0) break;
        run++;
      end
      chk("tx_start_len", run, 32);
      w = 8'hA5;
      for (int k = 0; k < 8; k++) chk($sformatf("tx_bit%0d", k), txd_log[f + 32 * (k + 1) + 16], w[k]);
      hi = 0;
      for (int i = f + 288; i < f + 320; i++) if (txd_log[i]) hi++;
      chk("tx_stop_len", hi, 32);
    end
    chk("tx_ready_low", ready_low, 320);

    // Loopback, back-to-back words
    loopback_a = 1'b1;
    repeat (4) @(negedge clk);
    falls_a.delete(); qa.delete();
    tx_send(1'b0, 8'h3C);
    tx_send(1'b0, 8'hC3);
    ifa.tx_valid = 1'b0;
    expect_word(1'b0, "lb_word0", {2'b00, 8'h3C});
    expect_word(1'b0, "lb_word1", {2'b00, 8'hC3});
    found = 0;
    if (falls_a.size() > 0) foreach (falls_a[i]) if (falls_a[i] == falls_a[0] + 320) found = 1;
    chk("lb_no_gap", found, 1);
    repeat (BIT) @(negedge clk);
    loopback_a = 1'b0;
    repeat (BIT) @(negedge clk);

    // Even parity on the 8E2 instance
    drive_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    expect_word(1'b1, "par_bad", {2'b10, 8'h07});
    drive_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    expect_word(1'b1, "par_good", {2'b00, 8'h07});

    // Framing error followed by a clean frame
    drive_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    expect_word(1'b0, "frame_err", {2'b01, 8'h55});
    drive_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
    expect_word(1'b0, "after_ferr", {2'b00, 8'h12});

    // Overrun with consumer stalled
    ifa.rx_ready = 1'b0;
    drive_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
    chk("ovr_first_no_ovr", ifa.rx_overrun, 0);
    drive_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    chk("ovr_data_kept", ifa.rx_data, 8'h11);
    chk("ovr_valid", ifa.rx_valid, 1);
    chk("ovr_flag", ifa.rx_overrun, 1);
    ifa.rx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("ovr_consumed", ifa.rx_valid, 0);
    chk("ovr_sticky", ifa.rx_overrun, 1);
    qa.delete();

    // Reset in the middle of the data bits
    tx_send(1'b0, 8'h96);
    ifa.tx_valid = 1'b0;
    repeat (BIT * 4) @(negedge clk);
    chk("mid_tx_busy", ifa.tx_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_txd", txd_a, 1);
    chk("mid_rst_tx_ready", ifa.tx_ready, 1);
    chk("mid_rst_ovr", ifa.rx_overrun, 0);
    chk("mid_rst_rx_valid", ifa.rx_valid, 0);
    rst = 1'b0;

    // Short low glitch must not start a word
    repeat (10) @(negedge clk);
    rxd_a = 1'b0;
    repeat (3) @(negedge clk);
    rxd_a = 1'b1;
    repeat (12 * BIT) @(negedge clk);
    chk("glitch_no_word", qa.size(), 0);
    chk("glitch_rx_valid", ifa.rx_valid, 0);
    chk("post_rst_txd_idle", txd_a, 1);

    // Random 8N1 frames with random stop bit
    for (int i = 0; i < 12; i++) begin
      logic [7:0] d;
      logic stop;
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      drive_frame(1'b0, d, 1'b0, 1'b0, stop);
      expect_word(1'b0, $sformatf("rnd_a%0d", i), {1'b0, !stop, d});
    end

    // Random 8E2 frames with random parity bit
    for (int i = 0; i < 8; i++) begin
      logic [7:0] d;
      logic p;
      d = 8'($urandom);
      p = 1'($urandom);
      drive_frame(1'b1, d, 1'b1, p, 1'b1);
      expect_word(1'b1, $sformatf("rnd_par%0d", i), {(p != (^d)), 1'b0, d});
    end

    // Random 8E2 loopback stream
    loopback_b = 1'b1;
    repeat (4) @(negedge clk);
    qb.delete();
    for (int i = 0; i < 8; i++) begin
      w = 8'($urandom);
      sent.push_back(w);
      tx_send(1'b1, w);
    end
    ifb.tx_valid = 1'b0;
    for (int i = 0; i < 8; i++) expect_word(1'b1, $sformatf("rnd_lb%0d", i), {2'b00, sent[i]});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected finish", cyc);
    $fatal(1);
  end
endmodule

// File: doc/uart_core_param.md
Name: uart_core_param

Overview:
- Parametrised full-duplex UART core. Successor to the fixed 8-bit tx/rx/baud-generator trio; all three are merged into one block on a single system clock.
- Baud timing comes from an internal 16x-oversample tick enable, not from derived clocks.
- Adds configurable width, parity and stop bits, valid/ready handshakes on both sides, error flags and internal loopback.
- Sits between a byte-stream producer/consumer and the txd/rxd pins.

Parameters:
- DIVISOR, 27: clk cycles per oversample tick; bit time = 16*DIVISOR cycles; legal range >=1.
- DATA_BITS, 8: payload width, 5..9, LSB first.
- PARITY_EN, 0: 1 inserts/checks a parity bit after the data bits.
- PARITY_ODD, 0: 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
- STOP_BITS, 1: 1 or 2 stop bits transmitted; RX checks only the first.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is synchronous and active-high.
- loopback  input  1  1 = RX input taken from internal txd instead of rxd; sampled at each RX start detect.
- tx_data  input  DATA_BITS  word to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  TX idle and able to accept a word.
- txd  output  1  serial out, idle high.
- rxd  input  1  serial in, asynchronous.
- rx_data  output  DATA_BITS  received word.
- rx_valid  output  1  rx_data holds an unread word.
- rx_ready  input  1  consumer accepts rx_data.
- rx_parity_err  output  1  parity mismatch on the word in rx_data.
- rx_frame_err  output  1  first stop bit sampled low on the word in rx_data.
- rx_overrun  output  1  sticky; a word was lost because rx_valid was still high; cleared only by rst.

Behaviour:
- Reset (rst=1 at a clk edge):
  - txd=1, tx_ready=1; rx_valid, rx_parity_err, rx_frame_err, rx_overrun = 0; rx_data = 0.
  - Tick divider, both FSMs and the synchroniser return to idle (synchroniser flops = 1).
  - Reset mid-frame aborts the frame; no partial word is delivered.
- Tick: a free-running counter 0..DIVISOR-1 pulses tick for one clk when it wraps. TX and RX share it.
- TX FSM: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
  - Transfer happens when tx_valid && tx_ready at a clk edge. tx_data is latched into a shift register and tx_ready drops the next cycle.
  - Each state lasts 16 ticks. txd changes only on tick edges: START=0, DATA = shift LSB first, PARITY = XOR(data)^PARITY_ODD, STOP=1 for STOP_BITS*16 ticks.
  - tx_ready rises in the cycle the last stop tick completes, so back-to-back words have no idle gap.
  - tx_valid while tx_ready=0 is ignored; the producer must hold it.
- RX input path: 2-flop synchroniser on (loopback ? txd : rxd).
- RX FSM: IDLE -> START -> DATA -> PARITY (optional) -> STOP -> IDLE.
  - IDLE: a synchronised low seen on a tick starts the tick count.
  - START: re-sampled after 8 ticks; if high, it is a glitch and the FSM returns to IDLE.
  - Thereafter each bit is sampled every 16 ticks (mid-bit).
  - STOP: the mid-bit sample determines frame_err. The FSM returns to IDLE immediately after the sample, allowing a half-bit of resync margin.
- RX output register:
  - At the stop sample, the word and its flags load into rx_data/rx_parity_err/rx_frame_err and rx_valid=1 on the next cycle.
  - rx_valid && rx_ready at an edge clears rx_valid.
  - If a word completes while rx_valid=1 and rx_ready=0: the old word is kept, the new word is discarded, rx_overrun is set.
  - Completion and rx_ready in the same cycle: the old word is consumed, the new word is loaded, rx_valid stays 1, no overrun.
- A framing error is still delivered as a word. RX never blocks on a stuck-low line: after a frame error it waits for a high sample before re-arming the start detect.

Test Plan:
- DIVISOR=2, 8N1, tx_data=8'hA5 handshake from reset -> txd low for exactly 32 clk, then bits 1,0,1,0,0,1,0,1 at 32 clk each, then high 32 clk. tx_ready low 320 clk total.
- Loopback=1, send 8'h3C then 8'hC3 back-to-back with rx_ready=1 -> rx_valid pulses twice with 3C then C3, error flags 0, no idle gap on txd.
- PARITY_EN=1, PARITY_ODD=0, rxd driven with 8'h07 and parity bit 0 -> rx_data=07, rx_parity_err=1. With parity bit 1 -> rx_parity_err=0.
- rxd frame 8'h55 with stop bit forced 0 -> rx_data=55, rx_frame_err=1. A following valid frame 8'h12 after line returns high is received cleanly.
- rx_ready held 0, two frames 8'h11 then 8'h22 -> rx_data stays 11, rx_overrun=1 and sticky until rst.
- rst asserted mid-way through the TX data bits and a 3-clk low glitch on rxd -> txd=1 and tx_ready=1 the cycle after rst; the glitch produces no rx_valid.
